merger_tree_p16_l128: RTL and testbench

//  Merges 2*L=256 independently sorted 32-bit record streams into one sorted stream.

---
 rtl/merger_pkg.sv | 24 ++
 rtl/merger_node.sv | 88 ++++++++
 rtl/merger_tree_p16_l128.sv | 55 +++++
 tb/tb_merger_tree_p16_l128.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/merger_pkg.sv
// merger_pkg: shared widths, record type and tree geometry helpers for the merger tree
package merger_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int P = 16;
    localparam int L = 128;
    localparam int LEAF_CNT = 2 * L;
    localparam int LEVELS = $clog2(LEAF_CNT);
    localparam int BUF_GROUPS = 4;

    typedef logic [DATA_WIDTH-1:0] record_t;

    // records per output group of a node at depth d (root is depth 0)
    function automatic int w_of(input int d);
        return ((P >> d) > 0) ? (P >> d) : 1;
    endfunction

    // record offset of depth d inside the flattened per-level data bus
    function automatic int rec_off(input int d);
        int s;
        s = 0;
        for (int e = 0; e < d; e++) s += (1 << e) * w_of(e);
        return s;
    endfunction
endpackage

// File: rtl/merger_node.sv
// merger_node: merges two sorted child streams, emitting the top W_OUT records per fire
module merger_node
    import merger_pkg::*;
#(
    parameter int W_IN  = 1,
    parameter int W_OUT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    in_valid,
    input  logic [2*W_IN*DATA_WIDTH-1:0]  in_data,
    output logic [1:0]                    in_ready,
    output logic                          out_valid,
    output logic [W_OUT*DATA_WIDTH-1:0]   out_data,
    input  logic                          out_ready
);
    localparam int C = BUF_GROUPS * W_IN;
    localparam int IW = $clog2(C);
    localparam int CW = $clog2(C + 1);
    localparam logic [CW-1:0] W_OUT_C = CW'(W_OUT);
    localparam logic [CW-1:0] W_IN_C = CW'(W_IN);
    localparam logic [CW-1:0] ROOM_C = CW'(C - W_IN);

    record_t buf_q [2][C];
    record_t buf_d [2][C];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [CW-1:0] pop [2];
    logic [CW-1:0] base;
    logic [IW-1:0] ia, ib;
    logic [W_OUT*DATA_WIDTH-1:0] mrg;
    logic [1:0] push;
    logic take_a, fire;

    assign push = in_valid & in_ready;

    // Top W_OUT of both windows; a tie drains the left child first
    always_comb begin
        ia = '0;
        ib = '0;
        take_a = 1'b0;
        mrg = '0;
        for (int j = 0; j < W_OUT; j++) begin
            take_a = buf_q[0][ia] >= buf_q[1][ib];
            mrg[j*DATA_WIDTH +: DATA_WIDTH] = take_a ? buf_q[0][ia] : buf_q[1][ib];
            ia = ia + IW'(take_a);
            ib = ib + IW'(!take_a);
        end
    end

    // Fire only with a full window on both sides so the chosen records are the global maximum
    always_comb begin
        fire = (cnt_q[0] >= W_OUT_C) && (cnt_q[1] >= W_OUT_C) && (!out_valid || out_ready);
        pop[0] = fire ? CW'(ia) : '0;
        pop[1] = fire ? CW'(ib) : '0;
        in_ready[0] = !rst && (cnt_q[0] <= ROOM_C);
        in_ready[1] = !rst && (cnt_q[1] <= ROOM_C);
    end

    // Shift out consumed records, then append an accepted child group behind the survivors
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        base = '0;
        for (int s = 0; s < 2; s++) begin
            base = cnt_q[s] - pop[s];
            for (int i = 0; i < C; i++)
                buf_d[s][i] = (i + int'(pop[s]) < C) ? buf_q[s][IW'(i) + IW'(pop[s])] : '0;
            for (int j = 0; j < W_IN; j++)
                if (push[s]) buf_d[s][IW'(base) + IW'(j)] = in_data[(s*W_IN+j)*DATA_WIDTH +: DATA_WIDTH];
            cnt_d[s] = base + (push[s] ? W_IN_C : '0);
        end
    end

    // Buffer storage and the registered output group
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (rst) begin
            cnt_q <= '{default: '0};
            out_valid <= 1'b0;
            out_data <= '0;
        end else begin
            cnt_q <= cnt_d;
            out_valid <= fire || (out_valid && !out_ready);
            if (fire) out_data <= mrg;
        end
    end
endmodule

// File: rtl/merger_tree_p16_l128.sv
// merger_tree_p16_l128: 256-leaf binary merge tree producing 16 sorted records per output write
module merger_tree_p16_l128
    import merger_pkg::*;
(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [LEAF_CNT*DATA_WIDTH-1:0] i_fifo,
    input  logic [LEAF_CNT-1:0]            i_fifo_empty,
    input  logic                           i_fifo_out_ready,
    output logic [LEAF_CNT-1:0]            o_fifo_read,
    output logic                           o_out_fifo_write,
    output logic [P*DATA_WIDTH-1:0]        o_data
);
    localparam int TOT = rec_off(LEVELS);

    logic [TOT*DATA_WIDTH-1:0] nd;
    logic [LEAF_CNT-1:1] nv, nr;
    logic [LEAF_CNT-1:0] leaf_rdy;

    assign nr[1] = i_fifo_out_ready && !i_rst;
    assign o_out_fifo_write = nv[1] && nr[1];
    assign o_data = nd[P*DATA_WIDTH-1:0];
    assign o_fifo_read = leaf_rdy & ~i_fifo_empty;

    for (genvar d = 0; d < LEVELS; d++) begin : g_lvl
        localparam int WO = w_of(d);
        localparam int WI = w_of(d + 1);
        localparam int OFF = rec_off(d);
        localparam int COFF = rec_off(d + 1);
        for (genvar n = 0; n < (1 << d); n++) begin : g_node
            localparam int I = (1 << d) + n;
            logic [1:0] cv, cr;
            logic [2*WI*DATA_WIDTH-1:0] cd;
            if (d == LEVELS - 1) begin : g_leaf
                assign cv = ~i_fifo_empty[2*n +: 2];
                assign cd = i_fifo[2*n*DATA_WIDTH +: 2*DATA_WIDTH];
                assign leaf_rdy[2*n +: 2] = cr;
            end else begin : g_inner
                assign cv = nv[2*I +: 2];
                assign cd = nd[(COFF + 2*n*WI)*DATA_WIDTH +: 2*WI*DATA_WIDTH];
                assign nr[2*I +: 2] = cr;
            end
            merger_node #(.W_IN(WI), .W_OUT(WO)) u_node (
                .clk(i_clk),
                .rst(i_rst),
                .in_valid(cv),
                .in_data(cd),
                .in_ready(cr),
                .out_valid(nv[I]),
                .out_data(nd[(OFF + n*WO)*DATA_WIDTH +: WO*DATA_WIDTH]),
                .out_ready(nr[I])
            );
        end
    end
endmodule

// File: tb/tb_merger_tree_p16_l128.sv
// tb_merger_tree_p16_l128: randomized leaf streams checked against a sorted-multiset reference
module tb_merger_tree_p16_l128;
    import merger_pkg::*;

    localparam int NZ = 16;
    localparam int NZERO = 20;
    localparam int BEATS = LEAF_CNT * NZ / P;
    localparam int BW = P * DATA_WIDTH;

    logic i_clk = 1'b0;
    logic i_rst;
    logic [LEAF_CNT*DATA_WIDTH-1:0] i_fifo;
    logic [LEAF_CNT-1:0] i_fifo_empty;
    logic i_fifo_out_ready;
    logic [LEAF_CNT-1:0] o_fifo_read;
    logic o_out_fifo_write;
    logic [BW-1:0] o_data;

    logic [31:0] lq [LEAF_CNT][$];
    logic [31:0] keep [LEAF_CNT][NZ];
    logic [31:0] exp_q [$];
    logic [BW-1:0] beats [$];
    int tests = 0, fails = 0, rd_viol = 0, wr_viol = 0, cyc = 0;
    bit toggle = 1'b0;

    merger_tree_p16_l128 dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_fifo(i_fifo),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_out_ready(i_fifo_out_ready),
        .o_fifo_read(o_fifo_read),
        .o_out_fifo_write(o_out_fifo_write),
        .o_data(o_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_leaves();
        for (int k = 0; k < LEAF_CNT; k++) begin
            i_fifo_empty[k] = (lq[k].size() == 0);
            i_fifo[k*32 +: 32] = (lq[k].size() != 0) ? lq[k][0] : 32'd0;
        end
    endtask

    // one clock: sample outputs mid-cycle, then model the show-ahead pops after the edge
    task automatic step();
        logic [LEAF_CNT-1:0] rd;
        @(negedge i_clk);
        rd = o_fifo_read;
        rd_viol += $countones(rd & i_fifo_empty);
        if (o_out_fifo_write) begin
            if (!i_fifo_out_ready) wr_viol++;
            beats.push_back(o_data);
        end
        @(posedge i_clk);
        #1;
        for (int k = 0; k < LEAF_CNT; k++)
            if (rd[k] && lq[k].size() != 0) void'(lq[k].pop_front());
        drive_leaves();
        cyc++;
        i_fifo_out_ready = toggle ? ((cyc / 3) % 2 == 0) : 1'b1;
    endtask

    task automatic do_reset();
        toggle = 1'b0;
        i_fifo_out_ready = 1'b1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_read_early", o_fifo_read, '0);
        check("rst_write_early", o_out_fifo_write, '0);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("rst_read", o_fifo_read, '0);
        check("rst_write", o_out_fifo_write, '0);
        check("rst_data", o_data, '0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // mode 0: fresh random descending runs, 1: replay previous runs, 2: all fives
    task automatic load(input int mode);
        logic [31:0] x, v;
        exp_q.delete();
        for (int k = 0; k < LEAF_CNT; k++) begin
            lq[k].delete();
            if (mode == 0) begin
                x = $urandom_range(32'hFFFF_FFFF, 32'h1000_0000);
                for (int i = 0; i < NZ; i++) begin
                    keep[k][i] = x;
                    x = x - $urandom_range(1, 1 << 23);
                end
            end
            for (int i = 0; i < NZ; i++) begin
                v = (mode == 2) ? 32'd5 : keep[k][i];
                lq[k].push_back(v);
                exp_q.push_back(v);
            end
            for (int i = 0; i < NZERO; i++) begin
                lq[k].push_back(32'd0);
                exp_q.push_back(32'd0);
            end
        end
        exp_q.rsort();
        drive_leaves();
    endtask

    function automatic logic [BW-1:0] exp_beat(input int b);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < P; j++) r[j*32 +: 32] = exp_q[b*P + j];
        return r;
    endfunction

    task automatic run_sort(input bit tg, input string name);
        int bound, n;
        beats.delete();
        rd_viol = 0;
        wr_viol = 0;
        cyc = 0;
        toggle = tg;
        for (int c = 0; c < 8000 && beats.size() < BEATS; c++) step();
        check({name, "_beat_count"}, beats.size(), BEATS);
        repeat (100) step();
        bound = exp_q.size() / P;
        if (beats.size() > bound) check({name, "_beat_overflow"}, beats.size(), bound);
        n = (beats.size() < bound) ? beats.size() : bound;
        for (int b = 0; b < n; b++) check($sformatf("%s_beat%0d", name, b), beats[b], exp_beat(b));
        check({name, "_read_when_empty"}, rd_viol, 0);
        check({name, "_write_when_stalled"}, wr_viol, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_fifo_out_ready = 1'b1;
        drive_leaves();
        do_reset();

        load(0);
        run_sort(1'b0, "sort");
        do_reset();

        load(1);
        run_sort(1'b1, "bp");
        do_reset();

        load(2);
        run_sort(1'b0, "ties");
        do_reset();

        for (int k = 0; k < LEAF_CNT; k++) lq[k].delete();
        drive_leaves();
        beats.delete();
        rd_viol = 0;
        repeat (100) step();
        check("empty_reads", rd_viol, 0);
        check("empty_writes", beats.size(), 0);

        load(0);
        repeat (60) step();
        do_reset();
        load(0);
        run_sort(1'b0, "rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
